// File: rtl/pipe_stage_regs.sv
// Pipeline-register bank for a five-stage core: PCF, IF/ID, ID/EX, EX/MEM and MEM/WB
// control/tag fields driven by hazard_unit stall/flush controls, plus stall/bubble counters.
module pipe_stage_regs #(
    parameter int PC_W   = 32,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [PC_W-1:0]   pc_next,
    input  logic [PC_W-1:0]   instr_f,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              PCSrcD,
    output logic [PC_W-1:0]   PCF,
    output logic [PC_W-1:0]   InstrD,
    output logic [PC_W-1:0]   PCD,
    output logic              validD,
    output logic [REG_AW-1:0] RA1E,
    output logic [REG_AW-1:0] RA2E,
    output logic [REG_AW-1:0] WA3E,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              PCSrcE,
    output logic              validE,
    output logic [REG_AW-1:0] WA3M,
    output logic              RegWriteM,
    output logic              PCSrcM,
    output logic [REG_AW-1:0] WA3W,
    output logic              RegWriteW,
    output logic              PCSrcW,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [PC_W-1:0] instr;
        logic [PC_W-1:0] pc;
        logic            valid;
    } if_id_t;

    typedef struct packed {
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [REG_AW-1:0] wa3;
        logic              reg_write;
        logic              mem_to_reg;
        logic              pc_src;
        logic              valid;
    } id_ex_t;

    typedef struct packed {
        logic [REG_AW-1:0] wa3;
        logic              reg_write;
        logic              pc_src;
    } tail_t;

    logic [PC_W-1:0] pcf_q;
    logic [PC_W-1:0] pcf_next;
    if_id_t          if_id_q;
    if_id_t          if_id_next;
    id_ex_t          id_ex_q;
    id_ex_t          id_ex_next;
    tail_t           ex_mem_q;
    tail_t           mem_wb_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;
    logic             stall_inc;
    logic             bubble_inc;

    always_comb begin
        pcf_next = pcf_q;
        if (!StallF) begin
            pcf_next = pc_next;
        end
    end

    // Flush beats stall so a squashed instruction can never be held in decode.
    always_comb begin
        if_id_next = if_id_q;
        if (FlushD) begin
            if_id_next = '0;
        end else if (!StallD) begin
            if_id_next.instr = instr_f;
            if_id_next.pc    = pcf_q;
            if_id_next.valid = 1'b1;
        end
    end

    // Controls are qualified by validD so a bubble in decode never writes or redirects.
    always_comb begin
        id_ex_next = '0;
        if (!FlushE) begin
            id_ex_next.ra1        = RA1D;
            id_ex_next.ra2        = RA2D;
            id_ex_next.wa3        = WA3D;
            id_ex_next.reg_write  = RegWriteD & if_id_q.valid;
            id_ex_next.mem_to_reg = MemtoRegD & if_id_q.valid;
            id_ex_next.pc_src     = PCSrcD & if_id_q.valid;
            id_ex_next.valid      = if_id_q.valid;
        end
    end

    assign stall_inc  = StallD && (stall_q != {CNT_W{1'b1}});
    assign bubble_inc = FlushE && if_id_q.valid && (bubble_q != {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q   <= '0;
            if_id_q <= '0;
            id_ex_q <= '0;
        end else begin
            pcf_q   <= pcf_next;
            if_id_q <= if_id_next;
            id_ex_q <= id_ex_next;
        end
    end

    // The back end always advances; squashing happens only in front of execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q.wa3       <= id_ex_q.wa3;
            ex_mem_q.reg_write <= id_ex_q.reg_write;
            ex_mem_q.pc_src    <= id_ex_q.pc_src;
            mem_wb_q           <= ex_mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (stall_inc) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (bubble_inc) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign PCF        = pcf_q;
    assign InstrD     = if_id_q.instr;
    assign PCD        = if_id_q.pc;
    assign validD     = if_id_q.valid;
    assign RA1E       = id_ex_q.ra1;
    assign RA2E       = id_ex_q.ra2;
    assign WA3E       = id_ex_q.wa3;
    assign RegWriteE  = id_ex_q.reg_write;
    assign MemtoRegE  = id_ex_q.mem_to_reg;
    assign PCSrcE     = id_ex_q.pc_src;
    assign validE     = id_ex_q.valid;
    assign WA3M       = ex_mem_q.wa3;
    assign RegWriteM  = ex_mem_q.reg_write;
    assign PCSrcM     = ex_mem_q.pc_src;
    assign WA3W       = mem_wb_q.wa3;
    assign RegWriteW  = mem_wb_q.reg_write;
    assign PCSrcW     = mem_wb_q.pc_src;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: directed vector table, hand-written hazard
// sequences and randomized traffic against an instruction-level reference model.
module tb_pipe_stage_regs;

    localparam int PC_W   = 32;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
    logic [PC_W-1:0] pc_next = '0, instr_f = '0;
    logic [REG_AW-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSrcD = 1'b0;

    logic [PC_W-1:0] PCF, InstrD, PCD;
    logic validD;
    logic [REG_AW-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteE, MemtoRegE, PCSrcE, validE;
    logic RegWriteM, PCSrcM, RegWriteW, PCSrcW;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_regs #(.PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .pc_next(pc_next), .instr_f(instr_f), .RA1D(RA1D), .RA2D(RA2D),
        .WA3D(WA3D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .validD(validD), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
        .validE(validE), .WA3M(WA3M), .RegWriteM(RegWriteM), .PCSrcM(PCSrcM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic [PC_W-1:0] pcf, instr_d, pc_d;
        logic valid_d;
        logic [REG_AW-1:0] ra1_e, ra2_e, wa3_e;
        logic rw_e, m2r_e, pcs_e, valid_e;
        logic [REG_AW-1:0] wa3_m;
        logic rw_m, pcs_m;
        logic [REG_AW-1:0] wa3_w;
        logic rw_w, pcs_w;
        logic [CNT_W-1:0] stall, bubble;
    } obs_t;

    // One in-flight instruction as seen from execute onwards.
    typedef struct packed {
        logic valid;
        logic [REG_AW-1:0] ra1, ra2, wa3;
        logic rw, m2r, pcs;
    } ir_t;

    typedef struct {
        logic sf, sd, fd, fe;
        logic [PC_W-1:0] pcn, ins;
        logic [REG_AW-1:0] wa3;
        logic rw, pcs;
        logic [PC_W-1:0] e_pcf, e_instr, e_pcd;
        logic e_vd;
        logic [REG_AW-1:0] e_wa3e;
        logic e_ve, e_rwe, e_pcse;
        logic [REG_AW-1:0] e_wa3m;
        logic e_rwm, e_pcsm;
        logic [REG_AW-1:0] e_wa3w;
        logic e_rww, e_pcsw;
        int e_stall, e_bubble;
    } vec_t;

    logic [PC_W-1:0] m_pcf, m_instr_d, m_pc_d;
    logic m_valid_d;
    ir_t pipe [3];
    int m_stall, m_bubble;
    int checks = 0;
    int errors = 0;
    vec_t tbl [8];

    function automatic obs_t actualObs();
        obs_t o;
        o.pcf = PCF; o.instr_d = InstrD; o.pc_d = PCD; o.valid_d = validD;
        o.ra1_e = RA1E; o.ra2_e = RA2E; o.wa3_e = WA3E;
        o.rw_e = RegWriteE; o.m2r_e = MemtoRegE; o.pcs_e = PCSrcE; o.valid_e = validE;
        o.wa3_m = WA3M; o.rw_m = RegWriteM; o.pcs_m = PCSrcM;
        o.wa3_w = WA3W; o.rw_w = RegWriteW; o.pcs_w = PCSrcW;
        o.stall = stall_cnt; o.bubble = bubble_cnt;
        return o;
    endfunction

    function automatic obs_t modelObs();
        obs_t o;
        o.pcf = m_pcf; o.instr_d = m_instr_d; o.pc_d = m_pc_d; o.valid_d = m_valid_d;
        o.ra1_e = pipe[0].ra1; o.ra2_e = pipe[0].ra2; o.wa3_e = pipe[0].wa3;
        o.rw_e = pipe[0].rw; o.m2r_e = pipe[0].m2r; o.pcs_e = pipe[0].pcs;
        o.valid_e = pipe[0].valid;
        o.wa3_m = pipe[1].wa3; o.rw_m = pipe[1].rw; o.pcs_m = pipe[1].pcs;
        o.wa3_w = pipe[2].wa3; o.rw_w = pipe[2].rw; o.pcs_w = pipe[2].pcs;
        o.stall = CNT_W'(m_stall); o.bubble = CNT_W'(m_bubble);
        return o;
    endfunction

    task automatic modelReset();
        m_pcf = '0; m_instr_d = '0; m_pc_d = '0; m_valid_d = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_stall = 0; m_bubble = 0;
    endtask

    // Instruction-level view of one clock edge; everything uses pre-edge state.
    task automatic modelEdge();
        ir_t ne;
        ne = '0;
        if (!FlushE) begin
            ne.valid = m_valid_d;
            ne.ra1 = RA1D; ne.ra2 = RA2D; ne.wa3 = WA3D;
            ne.rw = RegWriteD && m_valid_d;
            ne.m2r = MemtoRegD && m_valid_d;
            ne.pcs = PCSrcD && m_valid_d;
        end
        if (StallD && m_stall < CNT_MAX) m_stall++;
        if (FlushE && m_valid_d && m_bubble < CNT_MAX) m_bubble++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = ne;
        if (FlushD) begin
            m_instr_d = '0; m_pc_d = '0; m_valid_d = 1'b0;
        end else if (!StallD) begin
            m_instr_d = instr_f; m_pc_d = m_pcf; m_valid_d = 1'b1;
        end
        if (!StallF) m_pcf = pc_next;
    endtask

    task automatic applyStimulus(input logic sf, sd, fd, fe, input logic [PC_W-1:0] pcn, ins,
                                 input logic [REG_AW-1:0] r1, r2, w, input logic rw, m2r, pcs);
        StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
        pc_next = pcn; instr_f = ins;
        RA1D = r1; RA2D = r2; WA3D = w;
        RegWriteD = rw; MemtoRegD = m2r; PCSrcD = pcs;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput(input string name);
        obs_t a, e;
        a = actualObs();
        e = modelObs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, a, e);
        end
    endtask

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic quiet(input logic [PC_W-1:0] pcn);
        applyStimulus(0, 0, 0, 0, pcn, $urandom, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        logic [120:0] act_v, exp_v;
        logic [PC_W-1:0] pc_exp;

        // sf sd fd fe pcn ins wa3 rw pcs | pcf instr pcd vd wa3e ve rwe pcse wa3m rwm pcsm wa3w rww pcsw stall bubble
        tbl[0] = '{0,0,0,0, 32'h4,   32'h11, 3'd3, 1,0, 32'h4,   32'h11, 32'h0,   1, 3'd3, 0,0,0, 3'd0,0,0, 3'd0,0,0, 0,0};
        tbl[1] = '{0,0,0,0, 32'h8,   32'h22, 3'd3, 1,0, 32'h8,   32'h22, 32'h4,   1, 3'd3, 1,1,0, 3'd3,0,0, 3'd0,0,0, 0,0};
        tbl[2] = '{0,0,0,0, 32'hC,   32'h33, 3'd5, 0,0, 32'hC,   32'h33, 32'h8,   1, 3'd5, 1,0,0, 3'd3,1,0, 3'd3,0,0, 0,0};
        tbl[3] = '{1,1,0,1, 32'h10,  32'h44, 3'd6, 1,0, 32'hC,   32'h33, 32'h8,   1, 3'd0, 0,0,0, 3'd5,0,0, 3'd3,1,0, 1,1};
        tbl[4] = '{0,0,0,0, 32'h10,  32'h44, 3'd2, 1,1, 32'h10,  32'h44, 32'hC,   1, 3'd2, 1,1,1, 3'd0,0,0, 3'd5,0,0, 1,1};
        tbl[5] = '{0,0,1,0, 32'h100, 32'h55, 3'd1, 0,0, 32'h100, 32'h0,  32'h0,   0, 3'd1, 1,0,0, 3'd2,1,1, 3'd0,0,0, 1,1};
        tbl[6] = '{0,1,1,0, 32'h104, 32'h66, 3'd7, 1,1, 32'h104, 32'h0,  32'h0,   0, 3'd7, 0,0,0, 3'd1,0,0, 3'd2,1,1, 2,1};
        tbl[7] = '{0,0,0,1, 32'h108, 32'h77, 3'd4, 1,0, 32'h108, 32'h77, 32'h104, 1, 3'd0, 0,0,0, 3'd7,0,0, 3'd1,0,0, 2,1};

        modelReset();
        #12;
        checkOutput("power_on_reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].fe, tbl[i].pcn, tbl[i].ins,
                          3'd1, 3'd2, tbl[i].wa3, tbl[i].rw, 1'b0, tbl[i].pcs);
            checkOutput($sformatf("vec%0d_model", i));
            act_v = {PCF, InstrD, PCD, validD, WA3E, validE, RegWriteE, PCSrcE, WA3M, RegWriteM,
                     PCSrcM, WA3W, RegWriteW, PCSrcW, stall_cnt, bubble_cnt};
            exp_v = {tbl[i].e_pcf, tbl[i].e_instr, tbl[i].e_pcd, tbl[i].e_vd, tbl[i].e_wa3e,
                     tbl[i].e_ve, tbl[i].e_rwe, tbl[i].e_pcse, tbl[i].e_wa3m, tbl[i].e_rwm,
                     tbl[i].e_pcsm, tbl[i].e_wa3w, tbl[i].e_rww, tbl[i].e_pcsw,
                     CNT_W'(tbl[i].e_stall), CNT_W'(tbl[i].e_bubble)};
            checkVal($sformatf("vec%0d_table", i), 128'(act_v), 128'(exp_v));
        end

        // Straight-line issue: a write to r3 reaches E, M, W on consecutive edges.
        pc_exp = m_pcf + 32'd4;
        applyStimulus(0, 0, 0, 0, pc_exp, 32'hABC, 3'd0, 3'd0, 3'd3, 1, 0, 0);
        checkVal("straight_E", {RegWriteE, WA3E}, {1'b1, 3'd3});
        checkVal("straight_pc1", PCF, pc_exp);
        pc_exp = pc_exp + 32'd4;
        quiet(pc_exp);
        checkVal("straight_M", {RegWriteM, WA3M}, {1'b1, 3'd3});
        checkVal("straight_pc2", PCF, pc_exp);
        pc_exp = pc_exp + 32'd4;
        quiet(pc_exp);
        checkVal("straight_W", {RegWriteW, WA3W}, {1'b1, 3'd3});
        checkVal("straight_pc3", PCF, pc_exp);

        // Mid-run async reset with a live pipeline.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 32'h40, 32'h99, 3'd1, 3'd2, 3'd6, 1, 0, 0);
        checkVal("pre_reset_state", {PCF, RegWriteW}, {32'h40, 1'b1});
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkVal("async_reset_zero", 128'(actualObs()), 128'd0);
        #2 rst_n = 1'b1;

        // Counter saturation with a narrow counter.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h80, 32'h5, 3'd0, 3'd0, 3'd0, 0, 0, 0);
            checkOutput($sformatf("sat_cycle%0d", i));
        end
        checkVal("stall_sat", 128'(stall_cnt), 128'(CNT_MAX));
        applyStimulus(0, 1, 0, 0, 32'h80, 32'h5, 3'd0, 3'd0, 3'd0, 0, 0, 0);
        checkVal("stall_sat_hold", 128'(stall_cnt), 128'(CNT_MAX));

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                modelReset();
                #1;
                checkOutput($sformatf("rand_reset%0d", i));
                #1 rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                          $urandom, $urandom, 3'($urandom), 3'($urandom), 3'($urandom),
                          1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
